// File: rtl/graphics_pkg.sv
`default_nettype none
// ============================================================================
// Module   : graphics_pkg
// Purpose  : Shared fragment, material and triangle-id types for raster lanes.
// Revision : 1.0
// ============================================================================
package graphics_pkg;

   localparam int FRAG_COORD_W = 17;

   typedef struct packed {
      logic [FRAG_COORD_W-1:0] x;
      logic [FRAG_COORD_W-1:0] y;
      logic [FRAG_COORD_W-1:0] z;
   } fragment_t;

   typedef logic [11:0] material_t;
   typedef logic [15:0] triangle_id_t;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/fragment_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fragment_arbiter_if
// Purpose  : Lane-side request bundle and shader-side forwarded fragment.
// Revision : 1.0
// ============================================================================
interface fragment_arbiter_if
   import graphics_pkg::*;
#(
   parameter int NUM_SRC = 4
);
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic         [NUM_SRC-1:0] valid_in;
   logic         [NUM_SRC-1:0] ready_out;
   triangle_id_t [NUM_SRC-1:0] triangle_id_in;
   fragment_t    [NUM_SRC-1:0] fragment_in;
   material_t    [NUM_SRC-1:0] material_in;

   logic                       valid_out;
   triangle_id_t               triangle_id_out;
   fragment_t                  fragment_out;
   material_t                  material_out;
   logic         [SRC_W-1:0]   src_out;
   logic                       first_out;

   modport master (
      output valid_in, triangle_id_in, fragment_in, material_in,
      input  ready_out, valid_out, triangle_id_out, fragment_out,
             material_out, src_out, first_out
   );

   modport slave (
      input  valid_in, triangle_id_in, fragment_in, material_in,
      output ready_out, valid_out, triangle_id_out, fragment_out,
             material_out, src_out, first_out
   );
endinterface
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Purpose  : Combinational first-one finder starting at a rotating pointer.
// Revision : 1.0
// ============================================================================
module rr_priority_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  wire logic [N-1:0] i_req,
   input  wire logic [W-1:0] i_start,
   output logic      [N-1:0] o_grant,
   output logic      [W-1:0] o_idx,
   output logic              o_found
);
   int w_j;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_found = 1'b0;
      w_j     = 0;
      for (int k = 0; k < N; k++) begin
         w_j = int'(i_start) + k;
         if (w_j >= N) w_j = w_j - N;
         if (!o_found && i_req[w_j]) begin
            o_grant[w_j] = 1'b1;
            o_idx        = W'(w_j);
            o_found      = 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/fragment_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fragment_arbiter
// Purpose  : Round-robin, triangle-burst-locked arbiter feeding one shader.
// Revision : 1.0
// ============================================================================
module fragment_arbiter
   import graphics_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int MAX_BURST = 16
) (
   input  wire logic          clk_in,
   input  wire logic          rst_in,
   input  wire logic          hold_in,
   fragment_arbiter_if.slave  bus
);
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   arb_state_t         r_state;
   logic [SRC_W-1:0]   r_owner;
   logic [7:0]         r_burst_cnt;
   triangle_id_t       r_lock_tri;
   logic [SRC_W-1:0]   r_rr_ptr;

   logic               r_valid_out;
   triangle_id_t       r_tri_out;
   fragment_t          r_frag_out;
   material_t          r_mat_out;
   logic [SRC_W-1:0]   r_src_out;
   logic               r_first_out;

   logic [NUM_SRC-1:0] w_pick_grant;
   logic [SRC_W-1:0]   w_pick_idx;
   logic               w_pick_found;
   logic [SRC_W-1:0]   w_next_ptr;
   logic               w_continue;
   logic [NUM_SRC-1:0] w_ready;
   logic [SRC_W-1:0]   w_sel;
   logic               w_take;

   rr_priority_pick #(
      .N (NUM_SRC),
      .W (SRC_W)
   ) u_pick (
      .i_req   (bus.valid_in),
      .i_start (r_rr_ptr),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   assign w_next_ptr = (w_pick_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_pick_idx + 1'b1;

   // The owner keeps the shader while its triangle continues and the burst budget lasts.
   always_comb begin
      w_continue = (r_state == ST_LOCKED) && !hold_in && bus.valid_in[r_owner]
                   && (bus.triangle_id_in[r_owner] == r_lock_tri)
                   && (r_burst_cnt < 8'(MAX_BURST));
      w_ready = '0;
      w_sel   = w_pick_idx;
      if (!rst_in && !hold_in) begin
         if (w_continue) begin
            w_ready = NUM_SRC'(1) << r_owner;
            w_sel   = r_owner;
         end else if (w_pick_found) begin
            w_ready = w_pick_grant;
         end
      end
      w_take = |w_ready;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state     <= ST_IDLE;
         r_owner     <= '0;
         r_burst_cnt <= '0;
         r_lock_tri  <= '0;
         r_rr_ptr    <= '0;
         r_valid_out <= 1'b0;
         r_tri_out   <= '0;
         r_frag_out  <= '0;
         r_mat_out   <= '0;
         r_src_out   <= '0;
         r_first_out <= 1'b0;
      end else begin
         if (!hold_in) begin
            if (w_continue) begin
               r_burst_cnt <= r_burst_cnt + 8'd1;
            end else if (w_pick_found) begin
               r_state     <= ST_LOCKED;
               r_owner     <= w_pick_idx;
               r_lock_tri  <= bus.triangle_id_in[w_pick_idx];
               r_burst_cnt <= 8'd1;
               r_rr_ptr    <= w_next_ptr;
            end else begin
               r_state <= ST_IDLE;
            end
         end
         r_valid_out <= w_take;
         if (w_take) begin
            r_tri_out   <= bus.triangle_id_in[w_sel];
            r_frag_out  <= bus.fragment_in[w_sel];
            r_mat_out   <= bus.material_in[w_sel];
            r_src_out   <= w_sel;
            r_first_out <= !w_continue;
         end
      end
   end

   assign bus.ready_out       = w_ready;
   assign bus.valid_out       = r_valid_out;
   assign bus.triangle_id_out = r_tri_out;
   assign bus.fragment_out    = r_frag_out;
   assign bus.material_out    = r_mat_out;
   assign bus.src_out         = r_src_out;
   assign bus.first_out       = r_first_out;
endmodule
`default_nettype wire

// File: tb/tb_fragment_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fragment_arbiter
// Purpose  : Directed self-checking bench for fragment_arbiter (4 lanes, burst 16).
// Revision : 1.0
// ============================================================================
module tb_fragment_arbiter;
   import graphics_pkg::*;

   localparam int NUM_SRC   = 4;
   localparam int MAX_BURST = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hold = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;

   fragment_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

   fragment_arbiter #(
      .NUM_SRC   (NUM_SRC),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk_in  (clk),
      .rst_in  (rst),
      .hold_in (hold),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic fragment_t mk_frag(input int lane, input int tri_id, input int n);
      fragment_t f;
      f.x = 17'(lane + 100);
      f.y = 17'(tri_id);
      f.z = 17'(n);
      return f;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_lane(input int lane, input logic v, input int tri_id, input int n);
      bus.valid_in[lane]       = v;
      bus.triangle_id_in[lane] = 16'(tri_id);
      bus.fragment_in[lane]    = mk_frag(lane, tri_id, n);
      bus.material_in[lane]    = 12'(tri_id * 3 + lane);
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_lane;
      int exp_cnt;
      bit exp_first;
      bus.valid_in       = '0;
      bus.triangle_id_in = '0;
      bus.fragment_in    = '0;
      bus.material_in    = '0;

      // Reset state, including combinational ready suppression
      set_lane(1, 1'b1, 5, 0);
      #1;
      chk("rst_ready", 64'(bus.ready_out), 64'h0);
      tick(); tick();
      chk("rst_valid_out", 64'(bus.valid_out), 64'h0);
      chk("rst_tri_out", 64'(bus.triangle_id_out), 64'h0);
      chk("rst_src_out", 64'(bus.src_out), 64'h0);
      chk("rst_first_out", 64'(bus.first_out), 64'h0);
      set_lane(1, 1'b0, 0, 0);
      rst = 1'b0;

      // Single lane 2, tri 7, five beats
      for (int b = 0; b < 5; b++) begin
         set_lane(2, 1'b1, 7, b);
         #1;
         chk("t1_ready", 64'(bus.ready_out), 64'b0100);
         tick();
         chk("t1_valid", 64'(bus.valid_out), 64'h1);
         chk("t1_src", 64'(bus.src_out), 64'd2);
         chk("t1_first", 64'(bus.first_out), (b == 0) ? 64'h1 : 64'h0);
         chk("t1_frag", 64'(bus.fragment_out), 64'(mk_frag(2, 7, b)));
         chk("t1_mat", 64'(bus.material_out), 64'd23);
      end
      set_lane(2, 1'b0, 7, 0);
      #1;
      chk("t1_idle_ready", 64'(bus.ready_out), 64'h0);
      tick();
      chk("t1_idle_valid", 64'(bus.valid_out), 64'h0);
      chk("t1_idle_hold_tri", 64'(bus.triangle_id_out), 64'd7);

      // Lane 0 switches tri 3 -> 4 while lane 1 waits
      set_lane(0, 1'b1, 3, 0);
      set_lane(1, 1'b1, 9, 0);
      #1; chk("t2_l0_b0", 64'(bus.ready_out), 64'b0001);
      tick(); chk("t2_l0_b0_first", 64'(bus.first_out), 64'h1);
      #1; chk("t2_l0_b1", 64'(bus.ready_out), 64'b0001);
      tick(); chk("t2_l0_b1_first", 64'(bus.first_out), 64'h0);
      set_lane(0, 1'b1, 4, 0);
      #1; chk("t2_switch_to_l1", 64'(bus.ready_out), 64'b0010);
      tick();
      chk("t2_l1_src", 64'(bus.src_out), 64'd1);
      chk("t2_l1_first", 64'(bus.first_out), 64'h1);
      #1; chk("t2_l1_b1", 64'(bus.ready_out), 64'b0010);
      tick(); chk("t2_l1_b1_first", 64'(bus.first_out), 64'h0);
      set_lane(1, 1'b0, 9, 0);
      #1; chk("t2_l0_tri4", 64'(bus.ready_out), 64'b0001);
      tick();
      chk("t2_l0_tri4_out", 64'(bus.triangle_id_out), 64'd4);
      chk("t2_l0_tri4_first", 64'(bus.first_out), 64'h1);

      // Hold mid-burst at burst count 5, then finish the burst of 16
      set_lane(0, 1'b0, 4, 0);
      set_lane(3, 1'b1, 5, 0);
      for (int b = 0; b < 5; b++) begin
         #1; chk("t3_pre_ready", 64'(bus.ready_out), 64'b1000);
         tick();
      end
      hold = 1'b1;
      for (int b = 0; b < 3; b++) begin
         #1; chk("t3_hold_ready", 64'(bus.ready_out), 64'h0);
         tick(); chk("t3_hold_valid", 64'(bus.valid_out), 64'h0);
      end
      hold = 1'b0;
      set_lane(0, 1'b1, 1, 0);
      set_lane(1, 1'b1, 10, 0);
      set_lane(2, 1'b1, 11, 0);
      for (int b = 5; b < MAX_BURST; b++) begin
         #1; chk("t3_resume_ready", 64'(bus.ready_out), 64'b1000);
         tick();
         chk("t3_resume_first", 64'(bus.first_out), 64'h0);
         chk("t3_resume_valid", 64'(bus.valid_out), 64'h1);
      end

      // All lanes valid: bursts of exactly MAX_BURST in order 0,1,2,3
      exp_lane = 3;
      exp_cnt  = MAX_BURST;
      for (int c = 0; c < 70; c++) begin
         if (exp_cnt == MAX_BURST) begin
            exp_lane  = (exp_lane + 1) % NUM_SRC;
            exp_cnt   = 1;
            exp_first = 1'b1;
         end else begin
            exp_cnt++;
            exp_first = 1'b0;
         end
         #1; chk("t4_ready", 64'(bus.ready_out), 64'(1 << exp_lane));
         tick();
         chk("t4_src", 64'(bus.src_out), 64'(exp_lane));
         chk("t4_first", 64'(bus.first_out), 64'(exp_first));
         chk("t4_valid", 64'(bus.valid_out), 64'h1);
      end

      // Lane 1 alone, triangle changes every two beats
      set_lane(0, 1'b0, 0, 0);
      set_lane(2, 1'b0, 0, 0);
      set_lane(3, 1'b0, 0, 0);
      for (int b = 0; b < 6; b++) begin
         set_lane(1, 1'b1, 20 + b / 2, b);
         #1; chk("t5_ready", 64'(bus.ready_out), 64'b0010);
         tick();
         chk("t5_valid", 64'(bus.valid_out), 64'h1);
         chk("t5_first", 64'(bus.first_out), (b % 2 == 0) ? 64'h1 : 64'h0);
         chk("t5_tri", 64'(bus.triangle_id_out), 64'(20 + b / 2));
      end

      // Reset during a burst with data in flight
      set_lane(1, 1'b0, 0, 0);
      set_lane(2, 1'b1, 30, 0);
      for (int b = 0; b < 3; b++) begin
         #1; chk("t6_burst_ready", 64'(bus.ready_out), 64'b0100);
         tick();
      end
      chk("t6_inflight", 64'(bus.valid_out), 64'h1);
      set_lane(1, 1'b1, 31, 0);
      rst = 1'b1;
      #1; chk("t6_rst_ready", 64'(bus.ready_out), 64'h0);
      tick();
      chk("t6_rst_valid", 64'(bus.valid_out), 64'h0);
      chk("t6_rst_src", 64'(bus.src_out), 64'h0);
      chk("t6_rst_tri", 64'(bus.triangle_id_out), 64'h0);
      rst = 1'b0;
      #1; chk("t6_post_ready", 64'(bus.ready_out), 64'b0010);
      tick();
      chk("t6_post_src", 64'(bus.src_out), 64'd1);
      chk("t6_post_first", 64'(bus.first_out), 64'h1);
      chk("t6_post_tri", 64'(bus.triangle_id_out), 64'd31);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
